// File: rtl/rr_enable_arbiter8.sv
// Round-robin arbiter producing a registered one-hot write-enable vector and
// the matching data bit for a multi-enable register, plus a saturating grant count.
module rr_enable_arbiter8 #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         req_data,
    input  logic                 hold,
    input  logic                 clear_cnt,
    output logic [N-1:0]         en,
    output logic                 d_sel,
    output logic                 valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [CNT_W-1:0]     grant_cnt
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     en_q, en_d;
    logic             d_sel_q, d_sel_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             found_c;
    logic             grant_c;
    logic [IW-1:0]    sel_c;
    logic [IW-1:0]    idx_c;

    // Search starts one past the last grant, so the last winner is checked last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found_c = 1'b0;
        sel_c   = '0;
        idx_c   = '0;
        for (int k = 1; k <= N; k++) begin
            idx_c = IW'((int'(ptr_q) + k) % N);
            if (!found_c && req[idx_c]) begin
                found_c = 1'b1;
                sel_c   = idx_c;
            end
        end
    end

    assign grant_c = !hold && found_c;

    always_comb begin
        state_d    = grant_c ? GRANT : IDLE;
        en_d       = grant_c ? (N'(1) << sel_c) : '0;
        d_sel_d    = grant_c ? req_data[sel_c] : d_sel_q;
        grant_id_d = grant_c ? sel_c : grant_id_q;
        ptr_d      = grant_c ? sel_c : ptr_q;
        cnt_d      = cnt_q;
        if (clear_cnt) begin
            cnt_d = '0;
        end else if (grant_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ptr resets to N-1 so the first search after reset begins at index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            en_q       <= '0;
            d_sel_q    <= 1'b0;
            grant_id_q <= '0;
            ptr_q      <= IW'(N - 1);
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            en_q       <= en_d;
            d_sel_q    <= d_sel_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign en        = en_q;
    assign d_sel     = d_sel_q;
    assign valid     = (state_q == GRANT);
    assign grant_id  = grant_id_q;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_rr_enable_arbiter8.sv
// Scoreboard bench for rr_enable_arbiter8: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares the registered outputs.
module tb_rr_enable_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] req_data;
    logic       hold;
    logic       clear_cnt;
    logic [7:0] en;
    logic       d_sel;
    logic       valid;
    logic [2:0] grant_id;
    logic [3:0] grant_cnt;

    typedef struct {
        logic [7:0] en;
        logic       d_sel;
        logic [2:0] gid;
        logic [3:0] cnt;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cnt_model = 0;

    rr_enable_arbiter8 #(.N(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .hold      (hold),
        .clear_cnt (clear_cnt),
        .en        (en),
        .d_sel     (d_sel),
        .valid     (valid),
        .grant_id  (grant_id),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, queue the expected outputs.
    task automatic step(input logic [7:0] r, input logic [7:0] d, input logic h, input logic c,
                        input logic [7:0] e_en, input logic e_dsel, input logic [2:0] e_gid,
                        input string tag);
        exp_t e;
        req       = r;
        req_data  = d;
        hold      = h;
        clear_cnt = c;
        if (c) cnt_model = 0;
        else if (!h && (r != 8'h00) && (cnt_model < 15)) cnt_model++;
        @(posedge clk);
        #1;
        e.en    = e_en;
        e.d_sel = e_dsel;
        e.gid   = e_gid;
        e.cnt   = 4'(cnt_model);
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".en"},        32'(en),        32'h0);
        check({tag, ".valid"},     32'(valid),     32'h0);
        check({tag, ".d_sel"},     32'(d_sel),     32'h0);
        check({tag, ".grant_id"},  32'(grant_id),  32'h0);
        check({tag, ".grant_cnt"}, 32'(grant_cnt), 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) check("onehot0_en", 32'($onehot0(en)), 32'h1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".en"},        32'(en),        32'(e.en));
                check({e.tag, ".valid"},     32'(valid),     32'(e.en != 8'h00));
                check({e.tag, ".d_sel"},     32'(d_sel),     32'(e.d_sel));
                check({e.tag, ".grant_id"},  32'(grant_id),  32'(e.gid));
                check({e.tag, ".grant_cnt"}, 32'(grant_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        req       = 8'hFF;
        req_data  = 8'h00;
        hold      = 1'b0;
        clear_cnt = 1'b0;
        #2;
        check_reset_outputs("reset_initial");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_held_edge");
        @(negedge clk);
        rst_n = 1'b1;

        // Full rotation from ptr=7; data 0xAA gives d_sel = odd index.
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 8'hAA, 1'b0, 1'b0, 8'(1 << (i % 8)), 1'(i % 2), 3'(i % 8), "rotation");
        end

        // Single request, then idle: d_sel and grant_id hold.
        step(8'h08, 8'h08, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, "single");
        step(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd3, "single_idle");

        // Grant to 2, then 0/2 alternate under req=0x05.
        step(8'h04, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 3'd2, "wrap_setup");
        step(8'h05, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, "wrap_0a");
        step(8'h05, 8'h01, 1'b0, 1'b0, 8'h04, 1'b0, 3'd2, "wrap_2");
        step(8'h05, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, "wrap_0b");

        // Hold for 3 cycles with req=0x30; rotation resumes at 4 from ptr=0.
        for (int i = 0; i < 3; i++) begin
            step(8'h30, 8'h20, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, "hold");
        end
        step(8'h30, 8'h20, 1'b0, 1'b0, 8'h10, 1'b0, 3'd4, "hold_resume4");
        step(8'h30, 8'h20, 1'b0, 1'b0, 8'h20, 1'b1, 3'd5, "hold_resume5");
        step(8'h30, 8'h20, 1'b0, 1'b0, 8'h10, 1'b0, 3'd4, "hold_resume4b");

        // Counter sits saturated at 15 while grants continue from ptr=4.
        for (int i = 0; i < 8; i++) begin
            step(8'hFF, 8'hFF, 1'b0, 1'b0, 8'(1 << ((5 + i) % 8)), 1'b1, 3'((5 + i) % 8), "saturate");
        end

        // Clear beats a simultaneous grant; next grant counts from 0.
        step(8'hFF, 8'hFF, 1'b0, 1'b1, 8'h20, 1'b1, 3'd5, "clear_with_grant");
        step(8'hFF, 8'hFF, 1'b0, 1'b0, 8'h40, 1'b1, 3'd6, "after_clear");
        step(8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 3'd6, "clear_with_hold");

        // Only the last winner requesting: it is re-granted.
        step(8'h40, 8'h40, 1'b0, 1'b0, 8'h40, 1'b1, 3'd6, "regrant_a");
        step(8'h40, 8'h00, 1'b0, 1'b0, 8'h40, 1'b0, 3'd6, "regrant_b");

        // Asynchronous reset asserted while a grant is visible.
        step(8'hFF, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b1, 3'd7, "pre_reset");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_midstream");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cnt_model = 0;
        step(8'hFF, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, "post_reset");
        step(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, "post_reset_idle");

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
